// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch pulse driver.
// CHK_LAT follows the SR_DRV_SYNC_EN build option (readback synchronizer present or not).
package sr_drv_pkg;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] GAP_ENC   = 2'd1;
    localparam logic [1:0] PULSE_ENC = 2'd2;
    localparam logic [1:0] CHECK_ENC = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        GAP   = GAP_ENC,
        PULSE = PULSE_ENC,
        CHECK = CHECK_ENC
    } drv_state_t;

    // Cycles spent in CHECK before trusting the readback
`ifdef SR_DRV_SYNC_EN
    localparam int CHK_LAT = 2;
`else
    localparam int CHK_LAT = 1;
`endif

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-stage synchronizer for bringing the asynchronous latch readback into clk.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sr_pulse_driver.sv
// Write side of an external NOR SR latch: guard gap, one-shot set/reset pulse, readback check, retry.
// Build option SR_DRV_SYNC_EN inserts a 2-flop synchronizer on q_fb (CHK_LAT becomes 2).
module sr_pulse_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W   = 4,
    parameter int GAP_W     = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    input  logic q_fb,
    output logic s_out,
    output logic r_out,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int PH_W = $clog2(max3(PULSE_W, GAP_W, CHK_LAT) + 1);
    localparam int AT_W = $clog2(MAX_RETRY + 1);

    localparam logic [PH_W-1:0] GAP_LOAD   = PH_W'(GAP_W - 1);
    localparam logic [PH_W-1:0] PULSE_LOAD = PH_W'(PULSE_W - 1);
    localparam logic [PH_W-1:0] CHK_LOAD   = PH_W'(CHK_LAT - 1);
    localparam logic [AT_W-1:0] ATT_MAX    = AT_W'(MAX_RETRY);

    drv_state_t      state, state_nxt;
    logic [PH_W-1:0] phase, phase_nxt;
    logic [AT_W-1:0] attempts, att_nxt;
    logic            tgt, tgt_nxt;
    logic            done_nxt, err_nxt;
    logic            q_use;

`ifdef SR_DRV_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (q_fb),
        .q   (q_use)
    );
`else
    assign q_use = q_fb;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            attempts <= '0;
            tgt      <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            attempts <= att_nxt;
            tgt      <= tgt_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

    // phase counts down to zero and is reloaded on every state entry
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        att_nxt   = attempts;
        tgt_nxt   = tgt;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    tgt_nxt = req_level;
                    att_nxt = '0;
                    if (q_use == req_level) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = GAP;
                        phase_nxt = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (phase == '0) begin
                    state_nxt = PULSE;
                    phase_nxt = PULSE_LOAD;
                end else begin
                    phase_nxt = phase - PH_W'(1);
                end
            end
            PULSE: begin
                if (phase == '0) begin
                    state_nxt = CHECK;
                    phase_nxt = CHK_LOAD;
                    att_nxt   = attempts + AT_W'(1);
                end else begin
                    phase_nxt = phase - PH_W'(1);
                end
            end
            CHECK: begin
                if (phase != '0) begin
                    phase_nxt = phase - PH_W'(1);
                end else if (q_use == tgt) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (attempts < ATT_MAX) begin
                    state_nxt = GAP;
                    phase_nxt = GAP_LOAD;
                end else begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Drives decode from registered state only, so the async reset clears them at once
    assign s_out     = (state == PULSE) &  tgt;
    assign r_out     = (state == PULSE) & ~tgt;
    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE) & ~rst;

endmodule

// File: doc/sr_pulse_driver.md
# sr_pulse_driver

Drives the set/reset inputs of an external cross-coupled NOR SR latch from a synchronous level request. Converts each accepted request into a break-before-make guard gap followed by a fixed-width one-shot pulse on `s_out` (set) or `r_out` (reset), never both. It then reads the latch `q` back and retries or flags an error. Sits between clocked control logic and the asynchronous storage element: the write side of the latch.

## Interface
- `PULSE_W`, 4: cycles `s_out`/`r_out` held high per attempt; legal range ≥1.
- `GAP_W`, 2: cycles with both outputs low before every pulse; legal range ≥1.
- `MAX_RETRY`, 3: maximum pulse attempts per request; legal range ≥1.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_level`  in  1  target latch state (1 = set, 0 = reset).
- `req_ready`  out  1  high only in IDLE.
- `q_fb`  in  1  latch `q` readback; asynchronous to `clk`.
- `s_out`  out  1  set drive to latch.
- `r_out`  out  1  reset drive to latch.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse: latch confirmed at target.
- `err`  out  1  one-cycle pulse: retries exhausted, latch not at target.

## Operation
- Request handshake: accepted on the rising edge where `req_valid & req_ready`. `req_level` is captured into `tgt`, and the retry counter is cleared.
- Skip case: if the readback equals `req_level` at acceptance, no pulse is issued. `done` pulses on the next cycle and the FSM stays in IDLE.
- FSM states and transitions:
  - IDLE → GAP on acceptance (non-skip case).
  - GAP (GAP_W cycles) → PULSE.
  - PULSE (PULSE_W cycles) → CHECK.
  - CHECK (CHK_LAT cycles) → compare the readback with `tgt`:
    - Match: pulse `done`, go to IDLE.
    - Mismatch with attempts < MAX_RETRY: increment attempts, go to GAP.
    - Mismatch with attempts = MAX_RETRY: pulse `err`, go to IDLE.
- Output decode, from registered state and `tgt` only:
  - `s_out` = PULSE & `tgt`.
  - `r_out` = PULSE & ~`tgt`.
- Invariant: `s_out & r_out` is never 1, including across retries and reset.
- Counters:
  - One phase counter sized `$clog2(max(PULSE_W,GAP_W,CHK_LAT)+1)`; reloads on every state entry.
  - One attempt counter sized `$clog2(MAX_RETRY+1)`.
- `req_valid` outside IDLE is ignored. Requests are not queued.
- Reset mid-operation:
  - All outputs drop immediately, asynchronously.
  - The in-flight request is abandoned; no `done` or `err` is produced.
- Reset values: `s_out`=0, `r_out`=0, `done`=0, `err`=0, `busy`=0. `req_ready`=1 once reset deasserts; `tgt`=0.

## Timing
- Edge E0 is the acceptance edge. GAP occupies the cycles after E0 through E0+GAP_W.
- PULSE follows for PULSE_W cycles.
- CHECK follows for CHK_LAT cycles.
- `done`/`err` is high for the single cycle after edge E0+GAP_W+PULSE_W+CHK_LAT. Defaults with sync: 2+4+2 = 8.
- Each retry adds GAP_W+PULSE_W+CHK_LAT cycles.
- Back-to-back: `req_ready` is high in the same cycle `done` or `err` is high, so a new request can be accepted there.
- Skip case: `done` high in the cycle after E0; `busy` stays 0.

## Configuration
- `SR_DRV_SYNC_EN` defined:
  - `q_fb` passes through a 2-flop synchronizer before use; CHK_LAT = 2.
  - The synchronizer flops reset to 0.
- `SR_DRV_SYNC_EN` not defined:
  - `q_fb` is used directly and must already be synchronous to `clk`; CHK_LAT = 1.
- All latency figures scale with CHK_LAT accordingly.

## Structure
- Shared package `sr_drv_pkg`:
  - State encoding localparams: IDLE=0, GAP=1, PULSE=2, CHECK=3.
  - CHK_LAT constant, selected by `SR_DRV_SYNC_EN`.
- Sub-module `sync_2ff`: 1-bit two-stage synchronizer with async active-high reset. Instantiated only under `SR_DRV_SYNC_EN`.

## Test plan
- Reset, then set request with the latch model at q=0 → `s_out` high for exactly 4 cycles after a 2-cycle gap; `done` at E0+8; `r_out` never high.
- Request level 0 with the latch already at 0 → no pulse on either output; `done` in the cycle after E0; `busy` stays 0.
- Latch model ignores the first set pulse and honours the second → two GAP/PULSE sequences; `done` at E0+16; `err` never asserted.
- Latch model stuck at 0, MAX_RETRY=3 → three set pulses; `err` at E0+24; then `req_ready`=1.
- `rst` asserted mid-PULSE → `s_out` falls without waiting for a clock edge; no `done`/`err`; after deassertion `req_ready`=1 and all outputs 0.
- Alternating set/reset requests issued back-to-back on `done` cycles, with an assertion on `s_out & r_out` → assertion never fires; every request completes with `done`.
